// File: rtl/stage_decode.sv
// RV32I decode stage: splits a fetched word into fields, immediate and control
// bits behind one valid/ready pipeline register. Optional: DECODE_ILLEGAL_DETECT_EN.
module stage_decode #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_reg_we,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_alu_imm,
    output logic            out_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            reg_we_q, reg_we_d;
    logic            mem_rd_q, mem_rd_d;
    logic            mem_wr_q, mem_wr_d;
    logic            branch_q, branch_d;
    logic            jump_q, jump_d;
    logic            alu_imm_q, alu_imm_d;
    logic            illegal_q, illegal_d;

    logic            load;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] dec_imm;
    logic            dec_we, dec_mem_rd, dec_mem_wr, dec_branch, dec_jump, dec_alu_imm;
    logic            dec_illegal;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;

    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    // Opcode decode: immediate format and control bits for the incoming word.
    always_comb begin
        dec_imm     = '0;
        dec_we      = 1'b0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_branch  = 1'b0;
        dec_jump    = 1'b0;
        dec_alu_imm = 1'b0;
        dec_illegal = 1'b0;
        case (in_instr[6:0])
            OP_LUI, OP_AUIPC: begin
                dec_imm = imm_u; dec_we = 1'b1; dec_alu_imm = 1'b1;
            end
            OP_JAL: begin
                dec_imm = imm_j; dec_we = 1'b1; dec_jump = 1'b1;
            end
            OP_JALR: begin
                dec_imm = imm_i; dec_we = 1'b1; dec_jump = 1'b1; dec_alu_imm = 1'b1;
            end
            OP_BRANCH: begin
                dec_imm = imm_b; dec_branch = 1'b1;
            end
            OP_LOAD: begin
                dec_imm = imm_i; dec_we = 1'b1; dec_mem_rd = 1'b1; dec_alu_imm = 1'b1;
            end
            OP_STORE: begin
                dec_imm = imm_s; dec_mem_wr = 1'b1; dec_alu_imm = 1'b1;
            end
            OP_OPIMM: begin
                dec_imm = imm_i; dec_we = 1'b1; dec_alu_imm = 1'b1;
            end
            OP_OP: begin
                dec_we = 1'b1;
            end
            OP_MISC, OP_SYSTEM: begin
                dec_imm = imm_i;
            end
            default: begin
`ifdef DECODE_ILLEGAL_DETECT_EN
                dec_illegal = 1'b1;
`else
                dec_illegal = 1'b0;
`endif
            end
        endcase
`ifdef DECODE_ILLEGAL_DETECT_EN
        dec_illegal = dec_illegal | (in_instr[1:0] != 2'b11);
`endif
        // x0 is hard-wired zero, so never request a write to it
        if (in_instr[11:7] == 5'd0) begin
            dec_we = 1'b0;
        end else begin
            dec_we = dec_we;
        end
    end

    // Next-state for the pipeline register: load, drain, or hold on stall.
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        imm_d     = imm_q;
        reg_we_d  = reg_we_q;
        mem_rd_d  = mem_rd_q;
        mem_wr_d  = mem_wr_q;
        branch_d  = branch_q;
        jump_d    = jump_q;
        alu_imm_d = alu_imm_q;
        illegal_d = illegal_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (load) begin
            pc_d      = in_pc;
            instr_d   = in_instr;
            imm_d     = dec_imm;
            reg_we_d  = dec_we;
            mem_rd_d  = dec_mem_rd;
            mem_wr_d  = dec_mem_wr;
            branch_d  = dec_branch;
            jump_d    = dec_jump;
            alu_imm_d = dec_alu_imm;
            illegal_d = dec_illegal;
        end else begin
            pc_d = pc_q;
        end
    end

    // Pipeline register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            imm_q     <= '0;
            reg_we_q  <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            branch_q  <= 1'b0;
            jump_q    <= 1'b0;
            alu_imm_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            imm_q     <= imm_d;
            reg_we_q  <= reg_we_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            branch_q  <= branch_d;
            jump_q    <= jump_d;
            alu_imm_q <= alu_imm_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_opcode  = instr_q[6:0];
    assign out_rd      = instr_q[11:7];
    assign out_funct3  = instr_q[14:12];
    assign out_rs1     = instr_q[19:15];
    assign out_rs2     = instr_q[24:20];
    assign out_funct7  = instr_q[31:25];
    assign out_imm     = imm_q;
    assign out_reg_we  = reg_we_q;
    assign out_mem_rd  = mem_rd_q;
    assign out_mem_wr  = mem_wr_q;
    assign out_branch  = branch_q;
    assign out_jump    = jump_q;
    assign out_alu_imm = alu_imm_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_stage_decode.sv
// Bench for stage_decode: directed and random steps checked against a spec-level
// decode model and an in-order scoreboard. Honours DECODE_ILLEGAL_DETECT_EN.
module tb_stage_decode;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic        out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_alu_imm, out_illegal;

    int checks = 0;
    int errors = 0;

    stage_decode dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_reg_we(out_reg_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_branch(out_branch), .out_jump(out_jump), .out_alu_imm(out_alu_imm),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    logic [102:0] dut_b;
    assign dut_b = {out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
                    out_imm, out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_jump,
                    out_alu_imm, out_illegal};

    // Expected bundle straight from the instruction-set rules.
    function automatic logic [102:0] model(input logic [31:0] w, input logic [31:0] p);
        logic [31:0] imm;
        logic we, mrd, mwr, br, jmp, ai, ill;
        imm = 32'd0; we = 1'b0; mrd = 1'b0; mwr = 1'b0; br = 1'b0; jmp = 1'b0; ai = 1'b0; ill = 1'b0;
        case (w[6:0])
            7'b0110111, 7'b0010111: begin imm = {w[31:12], 12'h000}; we = 1'b1; ai = 1'b1; end
            7'b1101111: begin
                imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); we = 1'b1; jmp = 1'b1;
            end
            7'b1100111: begin imm = 32'($signed(w[31:20])); we = 1'b1; jmp = 1'b1; ai = 1'b1; end
            7'b1100011: begin
                imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); br = 1'b1;
            end
            7'b0000011: begin imm = 32'($signed(w[31:20])); we = 1'b1; mrd = 1'b1; ai = 1'b1; end
            7'b0100011: begin imm = 32'($signed({w[31:25], w[11:7]})); mwr = 1'b1; ai = 1'b1; end
            7'b0010011: begin imm = 32'($signed(w[31:20])); we = 1'b1; ai = 1'b1; end
            7'b0110011: we = 1'b1;
            7'b0001111, 7'b1110011: imm = 32'($signed(w[31:20]));
            default: ill = 1'b1;
        endcase
        if (w[11:7] == 5'd0) we = 1'b0;
        if (w[1:0] != 2'b11) ill = 1'b1;
`ifndef DECODE_ILLEGAL_DETECT_EN
        ill = 1'b0;
`endif
        return {p, w[6:0], w[11:7], w[19:15], w[24:20], w[14:12], w[31:25], imm,
                we, mrd, mwr, br, jmp, ai, ill};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected state of the output stage, advanced from the handshake rules.
    logic         ev = 1'b0;
    logic [102:0] eb = '0;
    logic         eb_known = 1'b0;
    logic [102:0] sb_q[$];

    task automatic step(input logic rs, input logic fl, input logic iv,
                        input logic [31:0] ins, input logic [31:0] p, input logic ordy);
        logic [102:0] front;
        rst = rs; flush = fl; in_valid = iv; in_instr = ins; in_pc = p; out_ready = ordy;
        @(negedge clk);
        if (!rs) check("in_ready", in_ready, !ev || ordy);
        if (!rs && !fl && ev && ordy) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1'b1, 1'b0);
            end else begin
                front = sb_q.pop_front();
                check("sb_order", dut_b, front);
            end
        end
        @(posedge clk);
        if (rs) begin
            ev = 1'b0; eb = '0; eb_known = 1'b1; sb_q.delete();
        end else if (fl) begin
            ev = 1'b0; eb_known = 1'b0; sb_q.delete();
        end else if (iv && (!ev || ordy)) begin
            ev = 1'b1; eb = model(ins, p); eb_known = 1'b1; sb_q.push_back(eb);
        end else if (ev && ordy) begin
            ev = 1'b0;
        end
        #1;
        check("out_valid", out_valid, ev);
        if (eb_known) check("bundle", dut_b, eb);
    endtask

    localparam logic [6:0] OPS [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                        7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                        7'b0110011, 7'b0001111, 7'b1110011};

    initial begin
        logic [31:0] w;
        logic [102:0] snap;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; out_ready = 1'b0;

        // Reset for three cycles
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_pc", out_pc, 32'd0);
        check("rst_ctrl", {out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_alu_imm, out_illegal}, 7'd0);

        // ADDI x5,x1,-1
        step(1'b0, 1'b0, 1'b1, 32'hFFF0_8293, 32'h0000_0100, 1'b1);
        check("addi_rd", out_rd, 5'd5);
        check("addi_rs1", out_rs1, 5'd1);
        check("addi_imm", out_imm, 32'hFFFF_FFFF);
        check("addi_ctrl", {out_reg_we, out_alu_imm, out_pc}, {1'b1, 1'b1, 32'h0000_0100});

        // BEQ x1,x2,-8 then SW x2,4(x1)
        step(1'b0, 1'b0, 1'b1, 32'hFE20_8CE3, 32'h0000_0104, 1'b1);
        check("beq_ctrl", {out_branch, out_reg_we}, 2'b10);
        check("beq_imm", out_imm, 32'hFFFF_FFF8);
        step(1'b0, 1'b0, 1'b1, 32'h0020_A223, 32'h0000_0108, 1'b1);
        check("sw_ctrl", {out_mem_wr, out_reg_we}, 2'b10);
        check("sw_imm", out_imm, 32'd4);

        // Stall four cycles with a word waiting, then release
        step(1'b0, 1'b0, 1'b1, 32'h0030_0393, 32'h0000_0200, 1'b1);
        snap = dut_b;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0041_0413, 32'h0000_0204, 1'b0);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_stable", dut_b, snap);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0041_0413, 32'h0000_0204, 1'b1);
        check("release_pc", out_pc, 32'h0000_0204);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);

        // Flush while holding a word and offering another
        step(1'b0, 1'b0, 1'b1, 32'h0050_0513, 32'h0000_0300, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h0060_0613, 32'h0000_0304, 1'b0);
        check("flush_valid", out_valid, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        check("flush_gone", out_valid, 1'b0);

        // Opcode outside the table
        step(1'b0, 1'b0, 1'b1, 32'h0000_007F, 32'h0000_0400, 1'b1);
        check("unk_ctrl", {out_reg_we, out_mem_rd, out_mem_wr, out_branch, out_jump, out_alu_imm}, 6'd0);
`ifdef DECODE_ILLEGAL_DETECT_EN
        check("unk_illegal", out_illegal, 1'b1);
`else
        check("unk_illegal", out_illegal, 1'b0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(3) != 0) w[6:0] = OPS[$urandom_range(10)];
            step(($urandom_range(99) == 0), ($urandom_range(15) == 0), 1'($urandom_range(1)),
                 w, $urandom, ($urandom_range(3) != 0));
        end

        // Drain and confirm nothing is left in flight
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        check("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
